// File: rtl/div_seq.sv
// Multi-cycle 32-bit signed/unsigned restoring divider for the EX stage.
// Returns {remainder, quotient} and stalls the pipeline while it iterates.
module div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        IDLE,
        BYZERO,
        RUN,
        DONE
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [64:0] part;
    logic [31:0] dvsr;
    logic        qneg;
    logic        rneg;

    logic [64:0] shifted;
    logic [33:0] diff;
    logic [64:0] next_part;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        mag1 = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
        mag2 = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
        shifted = part << 1;
        // 34-bit trial subtract so the borrow lands in its own bit
        diff = {1'b0, shifted[64:32]} - {2'b00, dvsr};
        if (diff[33])
            next_part = shifted;
        else
            next_part = {diff[32:0], shifted[31:1], 1'b1};
        quot = next_part[31:0];
        rem  = next_part[63:32];
    end

    always_comb begin
        stallreq_o = 1'b0;
        if (!annul_i) begin
            case (state)
                IDLE:       stallreq_o = start_i;
                BYZERO,
                RUN:        stallreq_o = 1'b1;
                default:    stallreq_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || annul_i) begin
            state    <= IDLE;
            cnt      <= '0;
            part     <= '0;
            dvsr     <= '0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (opdata2_i == 32'h0) begin
                            state <= BYZERO;
                        end else begin
                            state <= RUN;
                            cnt   <= '0;
                            part  <= {33'h0, mag1};
                            dvsr  <= mag2;
                            qneg  <= signed_div_i &
                                     (opdata1_i[31] ^ opdata2_i[31]);
                            rneg  <= signed_div_i & opdata1_i[31];
                        end
                    end
                end
                BYZERO: begin
                    state    <= DONE;
                    result_o <= '0;
                    ready_o  <= 1'b1;
                end
                RUN: begin
                    part <= next_part;
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        result_o <= {rneg ? -rem : rem,
                                     qneg ? -quot : quot};
                        ready_o  <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    if (!start_i) begin
                        state    <= IDLE;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed table, abort/reset
// sequences and a randomized scoreboard against an arithmetic model.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stallreq;

    int applied = 0;
    int miscomp = 0;

    div_seq dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .stallreq_o   (stallreq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
        int          stall;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscomp++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input bit sgn,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'h0) return 64'h0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_div(input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input bit scramble,
                           output logic [63:0] res, output int lat,
                           output int sc);
        @(negedge clk);
        signed_div = sgn;
        opdata1 = a;
        opdata2 = b;
        start = 1'b1;
        lat = 0;
        sc = 0;
        #1;
        while (!ready && lat < 40) begin
            if (stallreq) sc++;
            @(posedge clk);
            #1;
            lat++;
            if (scramble && !ready) begin
                opdata1 = $urandom;
                opdata2 = $urandom;
            end
        end
        check("ready_rise", {63'h0, ready}, 64'h1);
        check("stall_in_done", {63'h0, stallreq}, 64'h0);
        res = result;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("ready_clear", {63'h0, ready}, 64'h0);
        check("result_clear", result, 64'h0);
    endtask

    vec_t        tbl[$];
    logic [63:0] res;
    int          lat;
    int          sc;
    int          seen;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;

    initial begin
        rst = 1'b1;
        signed_div = 1'b0;
        opdata1 = '0;
        opdata2 = '0;
        start = 1'b0;
        annul = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", result, 64'h0);
        check("rst_ready", {63'h0, ready}, 64'h0);
        check("rst_stall", {63'h0, stallreq}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        tbl.push_back('{0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 33});
        tbl.push_back('{1, 32'hFFFFFFF9, 32'd2,
                        64'hFFFFFFFF_FFFFFFFD, 33, 33});
        tbl.push_back('{1, 32'd7, 32'hFFFFFFFE,
                        64'h00000001_FFFFFFFD, 33, 33});
        tbl.push_back('{0, 32'd5, 32'd0, 64'h0, 2, 2});
        tbl.push_back('{1, 32'h80000000, 32'hFFFFFFFF,
                        64'h00000000_80000000, 33, 33});
        tbl.push_back('{0, 32'hFFFFFFFF, 32'd1,
                        64'h00000000_FFFFFFFF, 33, 33});
        tbl.push_back('{0, 32'd3, 32'd9, 64'h00000003_00000000, 33, 33});
        for (int i = 0; i < tbl.size(); i++) begin
            run_div(tbl[i].sgn, tbl[i].a, tbl[i].b, 1'b0, res, lat, sc);
            check($sformatf("tbl%0d_result", i), res, tbl[i].exp);
            check($sformatf("tbl%0d_latency", i), 64'(lat),
                  64'(tbl[i].lat));
            check($sformatf("tbl%0d_stall", i), 64'(sc),
                  64'(tbl[i].stall));
        end

        // operands scrambled after the latch edge must not matter
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1, res, lat, sc);
        check("isolate_ovf", res, 64'h00000000_80000000);
        run_div(1'b0, 32'd1000003, 32'd97, 1'b1, res, lat, sc);
        check("isolate_u", res, ref_div(1'b0, 32'd1000003, 32'd97));

        // abort at iteration 10
        @(negedge clk);
        signed_div = 1'b0;
        opdata1 = 32'hFFFFFFFF;
        opdata2 = 32'd3;
        start = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        #1;
        check("annul_stall", {63'h0, stallreq}, 64'h0);
        @(posedge clk);
        #1;
        check("annul_ready", {63'h0, ready}, 64'h0);
        check("annul_result", result, 64'h0);
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready) seen++;
        end
        check("annul_no_ready", 64'(seen), 64'h0);
        run_div(1'b0, 32'd9, 32'd3, 1'b0, res, lat, sc);
        check("after_annul", res, 64'h00000000_00000003);

        // annul while result is held in DONE
        @(negedge clk);
        opdata1 = 32'd50;
        opdata2 = 32'd0;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("done_ready", {63'h0, ready}, 64'h1);
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk);
        #1;
        check("done_annul", {63'h0, ready}, 64'h0);
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;

        // reset at iteration 20
        @(negedge clk);
        signed_div = 1'b1;
        opdata1 = 32'h12345678;
        opdata2 = 32'h00000013;
        start = 1'b1;
        repeat (21) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("rstrun_result", result, 64'h0);
        check("rstrun_ready", {63'h0, ready}, 64'h0);
        check("rstrun_stall", {63'h0, stallreq}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready) seen++;
        end
        check("rstrun_no_ready", 64'(seen), 64'h0);

        for (int i = 0; i < 1000; i++) begin
            sgn = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, 15));
                1: b = -32'($urandom_range(1, 15));
                2: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            run_div(sgn, a, b, 1'b0, res, lat, sc);
            check($sformatf("rand%0d %0d %h/%h", i, sgn, a, b), res,
                  ref_div(sgn, a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, miscomp);
        $finish;
    end

endmodule
